// File: rtl/lzw_code_map.sv
// LZW string-to-code map: per-slot code RAM with valid bits, code allocator and sweep clear.
// Optional build macro LZW_MAP_AUTO_CLEAR_EN: a full-rejected allocate triggers an automatic clear.
module lzw_code_map #(
  parameter int ADDR_WIDTH = 11,
  parameter int CODE_WIDTH = 12,
  parameter int FIRST_CODE = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  resp_alloc,
  output logic [CODE_WIDTH-1:0] resp_code,
  output logic [CODE_WIDTH:0]   next_code,
  output logic                  full,
  output logic                  busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [CODE_WIDTH:0] FULL_CODE = {1'b1, {CODE_WIDTH{1'b0}}};
  localparam logic [CODE_WIDTH:0] FIRST_NC  = (CODE_WIDTH+1)'(FIRST_CODE);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [CODE_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;

  logic accept, is_lookup, is_alloc, is_clear;
  logic slot_hit, do_write, reject, clr_last;
  logic [CODE_WIDTH-1:0] slot_code;

  // The counter stops at one past the max code so full stays asserted.
  function automatic logic [CODE_WIDTH:0] sat_inc(input logic [CODE_WIDTH:0] v);
    return (v == FULL_CODE) ? v : v + 1'b1;
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = (state == CLEAR);
  assign full      = (next_code == FULL_CODE);

  assign accept    = req_valid & req_ready;
  assign is_lookup = accept & ((req_op == 2'b00) | (req_op == 2'b11));
  assign is_alloc  = accept & (req_op == 2'b01);
  assign is_clear  = accept & (req_op == 2'b10);
  assign slot_hit  = valid[req_addr];
  assign slot_code = mem[req_addr];
  assign do_write  = is_alloc & ~slot_hit & ~full;
  assign reject    = is_alloc & ~slot_hit & full;
  assign clr_last  = (clr_idx == {ADDR_WIDTH{1'b1}});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (is_clear) state_nxt = CLEAR;
`ifdef LZW_MAP_AUTO_CLEAR_EN
        if (reject) state_nxt = CLEAR;
`endif
      end
      CLEAR: if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= busy ? clr_idx + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_code <= FIRST_NC;
      valid     <= '0;
    end else if (busy) begin
      valid[clr_idx] <= 1'b0;
      if (clr_last) next_code <= FIRST_NC;
    end else if (do_write) begin
      valid[req_addr] <= 1'b1;
      next_code       <= sat_inc(next_code);
    end
  end

  // Code RAM carries no reset; invalid slots are never reported.
  always_ff @(posedge clk) begin
    if (busy) mem[clr_idx] <= '0;
    else if (do_write) mem[req_addr] <= next_code[CODE_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_alloc <= 1'b0;
      resp_code  <= '0;
    end else begin
      resp_valid <= is_lookup | is_alloc;
      if (is_lookup | is_alloc) begin
        resp_hit   <= slot_hit;
        resp_alloc <= do_write;
        if (slot_hit)      resp_code <= slot_code;
        else if (do_write) resp_code <= next_code[CODE_WIDTH-1:0];
        else               resp_code <= '0;
      end
    end
  end

endmodule
